// File: rtl/serial_pkg.sv
// Shared definitions for the serial word link (transmitter and receiver).
// State encoding, default frame width and bit-counter width helper.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } serial_state_e;

   localparam int SERIAL_WIDTH = 32;

   // Counter must be able to hold WIDTH itself, hence the +1.
   function automatic int serial_cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int SERIAL_CNT_W = serial_cnt_w(SERIAL_WIDTH);

endpackage : serial_pkg

// File: rtl/serial_word_hold.sv
// Output word register with valid/ready handshake; loads one cycle after word_load.
// A new word arriving while the held word is unaccepted is dropped and flagged by overrun_o.
module serial_word_hold
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_load,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (word_load) begin
         // Acceptance in the same cycle frees the slot for the new word.
         if (!valid_q || ready_i) begin
            data_d  = word_in;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule : serial_word_hold

// File: rtl/serial_rx.sv
// MSB-first deserializer with frame-length check; word valid one cycle after sdi_en falls.
// Output is valid/ready; an unaccepted word causes the next good word to be dropped (overrun).
module serial_rx
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             sdi_en,
   input  logic             sdi,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int CNT_W = serial_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   serial_state_e    state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_err_q, frame_err_d;
   logic             word_load;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      frame_err_d = 1'b0;
      word_load   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sdi_en) begin
               shift_d = {shift_q[WIDTH-2:0], sdi};
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sdi_en) begin
               if (cnt_q < CNT_FULL) begin
                  shift_d = {shift_q[WIDTH-2:0], sdi};
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = DRAIN;
               end
            end else begin
               if (cnt_q == CNT_FULL) begin
                  word_load = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            // Swallow the rest of any frame we did not see start.
            cnt_d = '0;
            if (!sdi_en) state_d = IDLE;
         end
         default: state_d = DRAIN;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q     <= DRAIN;
         shift_q     <= '0;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;

   serial_word_hold #(.WIDTH(WIDTH)) u_hold (
      .clk_i     (sclk),
      .rst_i     (rst),
      .word_in   (shift_q),
      .word_load (word_load),
      .ready_i   (rx_ready),
      .data_o    (rx_data),
      .valid_o   (rx_valid),
      .overrun_o (overrun)
   );

endmodule : serial_rx

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: good, short, long, overrun and reset-mid-frame cases.
module tb_serial_rx;

   logic        sclk;
   logic        rst;
   logic        sdi_en;
   logic        sdi;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        frame_err;
   logic        overrun;

   int vectors     = 0;
   int miscompares = 0;
   int err_cnt     = 0;
   int ovr_cnt     = 0;

   serial_rx #(.WIDTH(32)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .sdi_en    (sdi_en),
      .sdi       (sdi),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge sclk) begin
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive the top nbits of w, MSB first, with sdi_en high; sdi_en is left high.
   task automatic send_bits(input logic [31:0] w, input int nbits);
      for (int i = 31; i > 31 - nbits; i--) begin
         sdi_en = 1'b1;
         sdi    = w[i];
         tick();
      end
   endtask

   task automatic end_frame();
      sdi_en = 1'b0;
      sdi    = 1'b0;
      tick();
   endtask

   int err_at;

   initial begin
      rst      = 1'b1;
      sdi_en   = 1'b0;
      sdi      = 1'b0;
      rx_ready = 1'b1;
      tick();
      tick();
      check("rst_data",  rx_data,   32'h0);
      check("rst_valid", {31'd0, rx_valid},  32'h0);
      check("rst_ferr",  {31'd0, frame_err}, 32'h0);
      check("rst_ovr",   {31'd0, overrun},   32'h0);
      rst = 1'b0;
      tick();

      // Good frame, consumer ready.
      send_bits(32'hDEADBEEF, 32);
      check("good_novalid_early", {31'd0, rx_valid}, 32'h0);
      end_frame();
      check("good_valid", {31'd0, rx_valid}, 32'h1);
      check("good_data",  rx_data, 32'hDEADBEEF);
      tick();
      check("good_valid_one_cycle", {31'd0, rx_valid}, 32'h0);
      check("good_data_kept", rx_data, 32'hDEADBEEF);
      check("good_no_ferr", err_cnt, 32'd0);

      // Short frame: 31 bits.
      send_bits(32'hFFFFFFFF, 31);
      end_frame();
      check("short_ferr",  {31'd0, frame_err}, 32'h1);
      check("short_valid", {31'd0, rx_valid},  32'h0);
      tick();
      check("short_ferr_pulse", {31'd0, frame_err}, 32'h0);
      check("short_ferr_count", err_cnt, 32'd1);
      send_bits(32'h00000001, 32);
      end_frame();
      check("after_short_valid", {31'd0, rx_valid}, 32'h1);
      check("after_short_data",  rx_data, 32'h00000001);
      tick();

      // Long frame: 40 cycles of sdi_en.
      err_at = 0;
      for (int i = 1; i <= 40; i++) begin
         sdi_en = 1'b1;
         sdi    = i[0];
         tick();
         if (frame_err) err_at = i;
      end
      check("long_ferr_at_bit33", err_at, 32'd33);
      check("long_ferr_count", err_cnt, 32'd2);
      end_frame();
      check("long_no_valid", {31'd0, rx_valid}, 32'h0);
      send_bits(32'h12345678, 32);
      end_frame();
      check("after_long_valid", {31'd0, rx_valid}, 32'h1);
      check("after_long_data",  rx_data, 32'h12345678);
      tick();

      // Overrun: consumer stalled across two words.
      rx_ready = 1'b0;
      send_bits(32'hAAAAAAAA, 32);
      end_frame();
      check("ovr_first_data", rx_data, 32'hAAAAAAAA);
      send_bits(32'h55555555, 32);
      end_frame();
      check("ovr_pulse", {31'd0, overrun}, 32'h1);
      check("ovr_data_kept", rx_data, 32'hAAAAAAAA);
      check("ovr_valid_kept", {31'd0, rx_valid}, 32'h1);
      tick();
      check("ovr_pulse_end", {31'd0, overrun}, 32'h0);
      check("ovr_count", ovr_cnt, 32'd1);
      rx_ready = 1'b1;
      tick();
      check("ovr_drained", {31'd0, rx_valid}, 32'h0);

      // Acceptance on the same cycle the second word completes.
      rx_ready = 1'b0;
      send_bits(32'hAAAAAAAA, 32);
      end_frame();
      send_bits(32'h55555555, 32);
      rx_ready = 1'b1;
      end_frame();
      check("same_cycle_data",  rx_data, 32'h55555555);
      check("same_cycle_valid", {31'd0, rx_valid}, 32'h1);
      check("same_cycle_no_ovr", {31'd0, overrun}, 32'h0);
      tick();
      check("same_cycle_ovr_count", ovr_cnt, 32'd1);

      // Reset after bit 10 of a frame while sdi_en stays high.
      send_bits(32'hCAFEF00D, 10);
      rst    = 1'b1;
      sdi_en = 1'b1;
      sdi    = 1'b1;
      tick();
      check("midrst_data",  rx_data, 32'h0);
      check("midrst_valid", {31'd0, rx_valid}, 32'h0);
      rst = 1'b0;
      for (int i = 20; i >= 0; i--) begin
         sdi_en = 1'b1;
         sdi    = i[0];
         tick();
      end
      end_frame();
      check("midrst_no_ferr", err_cnt, 32'd2);
      check("midrst_no_valid", {31'd0, rx_valid}, 32'h0);
      send_bits(32'h0F0F0F0F, 32);
      end_frame();
      check("after_rst_valid", {31'd0, rx_valid}, 32'h1);
      check("after_rst_data",  rx_data, 32'h0F0F0F0F);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_serial_rx

// File: doc/serial_rx.md
# serial_rx

Deserializer for the 32-bit serial link; it is the receive-side partner of the serial word transmitter. It samples `sdi_en` (chip select) and `sdi` on `sclk`, shifts in bits MSB first, and checks that each frame is exactly `WIDTH` bits long. Good words are presented on a valid/ready output port. Short, long and dropped frames are flagged. It sits directly downstream of the transmitter, in the same `sclk` domain, and feeds the result/display logic.

## Interface
- `WIDTH`, 32: bits per frame and output word width.
- `sclk`  in  1: clock. Shared with the transmitter; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sdi_en`  in  1: frame enable from the transmitter's data enable. High for exactly WIDTH consecutive cycles per frame.
- `sdi`  in  1: serial data, MSB first. Valid on every cycle where `sdi_en`=1.
- `rx_data`  out  WIDTH: received word. Held stable while `rx_valid`=1.
- `rx_valid`  out  1: word available.
- `rx_ready`  in  1: consumer accepts the word when `rx_valid` && `rx_ready`.
- `frame_err`  out  1: one-cycle pulse on a short or long frame.
- `overrun`  out  1: one-cycle pulse when a good word is dropped because the output is still occupied.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0. Shift register and bit counter are 0. State is DRAIN.
- Bit counter width is clog2(WIDTH+1) bits and saturates at WIDTH. The shift register is WIDTH bits and shifts left, with `sdi` entering the LSB.
- **IDLE**
  - `sdi_en`=1: shift in `sdi`, set count=1, go to SHIFT.
  - Otherwise: stay in IDLE.
- **SHIFT**, with `sdi_en`=1:
  - count<WIDTH: shift in the bit and increment count.
  - count==WIDTH: the frame is too long. Pulse `frame_err`, discard the frame, go to DRAIN.
- **SHIFT**, with `sdi_en`=0:
  - count==WIDTH: deliver the word (see the output rules below) and go to IDLE.
  - count<WIDTH: the frame is short. Pulse `frame_err`, discard the frame, go to IDLE.
- **DRAIN**
  - Wait for `sdi_en`=0, then go to IDLE. No bits are captured in this state.
  - Because reset enters DRAIN, a frame already in progress when reset deasserts is ignored and does not raise an error.
- **Output rules**
  - If `rx_valid`=0, or `rx_valid` && `rx_ready` in the same cycle: load the new word and set `rx_valid`=1.
  - If `rx_valid`=1 and `rx_ready`=0: keep the old word, drop the new one, pulse `overrun`.
  - If an acceptance happens with no new word arriving: clear `rx_valid`. `rx_data` keeps its last value.
- `frame_err` and `overrun` never assert in the same cycle, since a word is only delivered on a good frame.
- Back-to-back frames need at least one `sdi_en`=0 cycle between them. A transmitter reload mid-frame keeps `sdi_en` high and therefore appears as a long frame.

## Timing
- Frame of WIDTH bits, first bit sampled at edge N: the last bit is at edge N+WIDTH-1 and `sdi_en`=0 is sampled at edge N+WIDTH.
- `rx_valid` is high after edge N+WIDTH, i.e. one cycle after the enable falls.
- `frame_err` for a short frame is high after the edge that samples `sdi_en`=0. For a long frame it is high after the edge that samples bit WIDTH+1.
- Throughput is one word per WIDTH+1 cycles. Input-to-output latency is one cycle after the frame end.
- `rst` takes priority over every other input on the same edge.

## Structure
- Shared package `serial_pkg` holds:
  - state encoding `IDLE`/`SHIFT`/`DRAIN` (2 bits);
  - default `SERIAL_WIDTH`=32;
  - the counter-width constant.
  The transmitter and receiver both use it.
- One sub-module, `serial_word_hold`: the WIDTH-bit output register with its valid/ready/overrun logic. Inputs are `word_in` and `word_load`.
- The frame FSM, shift register and counter stay in `serial_rx`.

## Test plan
- **Good frame:** drive 0xDEADBEEF MSB first for 32 cycles, then `sdi_en`=0, with `rx_ready`=1 → `rx_data`=0xDEADBEEF, `rx_valid` high for exactly one cycle, starting the cycle after the enable falls. `frame_err`=0.
- **Short frame:** 31 bits → `frame_err` pulses once, `rx_valid` stays 0. A following good frame of 0x00000001 is received correctly.
- **Long frame:** 40 bits of `sdi_en` high → `frame_err` at bit 33, no output. The DRAIN state then accepts the next good frame 0x12345678.
- **Overrun:**
  - With `rx_ready`=0, send 0xAAAAAAAA then 0x55555555 with a one-cycle gap → `rx_data` stays 0xAAAAAAAA and `overrun` pulses once.
  - Repeat with `rx_ready`=1 on the exact cycle the second word completes → `rx_data`=0x55555555, `rx_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `rst` after bit 10 of 0xCAFEF00D while `sdi_en` stays high → all outputs 0 and no `frame_err` for the remainder. The next full frame 0x0F0F0F0F is received.
- **End-to-end:** connect the real transmitter, pulse its load with 0x80000001 → receiver outputs 0x80000001, with `rx_valid` 34 cycles after the load pulse is registered.
